// File: rtl/axis_pipe_share_pkg.sv
// axis_pipe_share_pkg
// Shared types and helpers for the axis_pipe_share_arb slice.
//   arb_state_e : arbiter FSM states (IDLE arbitrates, GRANT moves beats)
//   rr_pick     : round-robin search over a 16-bit valid vector, starting
//                 from last+1. Callers zero-pad valid above their requester
//                 count, so the modulo-16 wrap gives the same winner as a
//                 modulo-NUM wrap.
package axis_pipe_share_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int RR_MAX = 16;
  localparam int RR_IW  = 4;

  function automatic logic [RR_IW-1:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                               input logic [RR_IW-1:0]  last);
    logic [RR_IW-1:0] idx;
    logic             found;
    rr_pick = last;
    found   = 1'b0;
    // k = RR_MAX wraps idx back to last itself, so it is considered last.
    for (int k = 1; k <= RR_MAX; k++) begin
      idx = last + RR_IW'(k);
      if (!found && valid[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/axis_pipe_share_arb_demux.sv
// axis_tid_demux
// Combinational return-path demux: steers one return stream to NUM
// per-requester outputs by r_tid. Data and last fan out to every requester;
// only the addressed valid bit is raised. An r_tid outside 0..NUM-1 is
// accepted and dropped so a corrupt id can never stall the pipe.
// Ports:
//   r_tvalid/r_tdata/r_tlast/r_tid  in   return beat from the shared pipe
//   r_tready                        out  ready back to the pipe
//   o_tvalid/o_tdata/o_tlast        out  per-requester return streams
//   o_tready                        in   per-requester ready
module axis_tid_demux #(
  parameter int NUM   = 4,
  parameter int DSIZE = 32,
  localparam int TW   = $clog2(NUM)
) (
  input  logic                 r_tvalid,
  input  logic [DSIZE-1:0]     r_tdata,
  input  logic                 r_tlast,
  input  logic [TW-1:0]        r_tid,
  output logic                 r_tready,
  output logic [NUM-1:0]       o_tvalid,
  output logic [NUM*DSIZE-1:0] o_tdata,
  output logic [NUM-1:0]       o_tlast,
  input  logic [NUM-1:0]       o_tready
);

  logic tid_ok;

  assign tid_ok  = (int'(r_tid) < NUM);
  assign o_tdata = {NUM{r_tdata}};
  assign o_tlast = {NUM{r_tlast}};

  always_comb begin
    o_tvalid = '0;
    r_tready = 1'b1;
    if (tid_ok) begin
      o_tvalid[r_tid] = r_tvalid;
      r_tready        = o_tready[r_tid];
    end
  end

endmodule

// File: rtl/axis_pipe_share_arb.sv
// axis_pipe_share_arb
// Shares one pipelined stream resource among NUM requesters. A two-state
// FSM arbitrates round robin (one bubble cycle per arbitration), a single
// output register drives the merged m stream tagged with the requester id,
// and a credit counter caps the beats in flight between s acceptance and
// r return at CREDITS. Return beats are demuxed back by r_tid.
// Build option:
//   AXIS_PIPE_SHARE_PKT_LOCK_EN defined   -> grant held until the granted
//                                            requester's tlast beat is taken
//   AXIS_PIPE_SHARE_PKT_LOCK_EN undefined -> grant released after every beat
// Ports:
//   aclk, aresetn                   clock, async active-low reset
//   s_tvalid/s_tdata/s_tlast        in   per-requester input streams
//   s_tready                        out  per-requester ready
//   m_tvalid/m_tdata/m_tlast/m_tid  out  merged stream into the pipe
//   m_tready                        in   pipe ready
//   r_tvalid/r_tdata/r_tlast/r_tid  in   return stream from the pipe
//   r_tready                        out  return ready
//   o_tvalid/o_tdata/o_tlast        out  per-requester return streams
//   o_tready                        in   per-requester return ready
module axis_pipe_share_arb
  import axis_pipe_share_pkg::*;
#(
  parameter int NUM     = 4,
  parameter int DSIZE   = 32,
  parameter int CREDITS = 8,
  localparam int TW     = $clog2(NUM),
  localparam int CW     = $clog2(CREDITS + 1)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [NUM-1:0]       s_tvalid,
  input  logic [NUM*DSIZE-1:0] s_tdata,
  input  logic [NUM-1:0]       s_tlast,
  output logic [NUM-1:0]       s_tready,
  output logic                 m_tvalid,
  output logic [DSIZE-1:0]     m_tdata,
  output logic                 m_tlast,
  output logic [TW-1:0]        m_tid,
  input  logic                 m_tready,
  input  logic                 r_tvalid,
  input  logic [DSIZE-1:0]     r_tdata,
  input  logic                 r_tlast,
  input  logic [TW-1:0]        r_tid,
  output logic                 r_tready,
  output logic [NUM-1:0]       o_tvalid,
  output logic [NUM*DSIZE-1:0] o_tdata,
  output logic [NUM-1:0]       o_tlast,
  input  logic [NUM-1:0]       o_tready
);

  arb_state_e       state, state_nxt;
  logic [TW-1:0]    grant, last;
  logic [CW-1:0]    count;
  logic [RR_IW-1:0] pick;
  logic             s_ok, s_hs, r_hs, grant_end;

  // The credit check looks only at the registered count; a return in the
  // same cycle frees its credit for the following cycle.
  assign s_ok = (state == GRANT) && (!m_tvalid || m_tready) && (count < CW'(CREDITS));
  assign s_hs = s_ok && s_tvalid[grant];
  assign r_hs = r_tvalid && r_tready;

  always_comb begin
    s_tready        = '0;
    s_tready[grant] = s_ok;
  end

`ifdef AXIS_PIPE_SHARE_PKT_LOCK_EN
  assign grant_end = s_tlast[grant];
`else
  assign grant_end = 1'b1;
`endif

  assign pick = rr_pick(RR_MAX'(s_tvalid), RR_IW'(last));

  // Arbitration FSM
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|s_tvalid)             state_nxt = GRANT;
      GRANT:   if (s_hs && grant_end)     state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant <= '0;
      last  <= TW'(NUM - 1);
    end else begin
      if (state == IDLE && |s_tvalid) grant <= pick[TW-1:0];
      if (state == GRANT && s_hs && grant_end) last <= grant;
    end
  end

  // Output register stage
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_tid    <= '0;
    end else if (s_hs) begin
      m_tvalid <= 1'b1;
      m_tdata  <= s_tdata[int'(grant)*DSIZE +: DSIZE];
      m_tlast  <= s_tlast[grant];
      m_tid    <= grant;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  // Credit counter; a return with nothing outstanding is absorbed at zero.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count <= '0;
    end else begin
      case ({s_hs, r_hs})
        2'b10:   count <= count + CW'(1);
        2'b01:   if (count != '0) count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  axis_tid_demux #(
    .NUM   (NUM),
    .DSIZE (DSIZE)
  ) u_demux (
    .r_tvalid (r_tvalid),
    .r_tdata  (r_tdata),
    .r_tlast  (r_tlast),
    .r_tid    (r_tid),
    .r_tready (r_tready),
    .o_tvalid (o_tvalid),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tready (o_tready)
  );

endmodule
